instr_fetch_unit: RTL and testbench

//  Upstream neighbour of cpu: generates fetch addresses and drives cpu.instruction.

---
 rtl/rv_fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package rv_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetched word paired with the address it was fetched from.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a registered head.
// The head register keeps its last value when the FIFO drains or is flushed.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   din,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_nxt;
  logic          push_eff;
  logic          pop_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Qualify push/pop; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    pop_eff  = pop && (count != '0);
    push_eff = push && ((count != CW'(DEPTH)) || pop_eff);
    rd_nxt   = ptr_inc(rd_ptr);
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO and drops any push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_eff)  rd_ptr <= rd_nxt;
      count <= count + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Entry storage, data only.
  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem[wr_ptr] <= din;
  end

  // Registered head: load the next oldest entry, or the incoming word when it becomes the oldest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (!flush) begin
      if (push_eff && ((count == '0) || (pop_eff && (count == CW'(1))))) begin
        head <= din;
      end else if (pop_eff && (count > CW'(1))) begin
        head <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory under a
// credit limit, buffers returned words with their PCs and hands them to the
// core. A redirect flushes buffered words and discards responses still in flight.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   pcq_count;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_ok;
  logic            buf_push;
  logic            buf_pop;
  fetch_entry_t    buf_din;
  fetch_entry_t    buf_head;
  fetch_entry_t    pcq_din;
  fetch_entry_t    pcq_head;

  assign instr_valid = (buf_count != '0);
  assign instr       = buf_head.instr;
  assign instr_pc    = buf_head.pc;
  assign imem_addr   = fetch_pc;

  // Credit check, handshake qualification and buffer/PC-queue controls.
  // Words in flight plus words buffered never exceed DEPTH, so a response always has room.
  always_comb begin
    credit_ok    = ({1'b0, inflight} + {1'b0, buf_count}) < (CW + 1)'(DEPTH);
    imem_req     = !rst && credit_ok && !redirect_valid;
    req_fire     = imem_req && imem_gnt;
    rsp_ok       = imem_rvalid && (inflight != '0);
    inflight_nxt = inflight + CW'(req_fire) - CW'(rsp_ok);
    buf_push     = rsp_ok && (discard == '0) && !redirect_valid;
    buf_pop      = instr_valid && instr_ready && !redirect_valid;
    buf_din      = '{instr: imem_rdata, pc: pcq_head.pc};
    pcq_din      = '{instr: '0, pc: fetch_pc};
  end

  // Fetch address, in-flight count and stale-response count.
  // A redirect marks everything still outstanding after this cycle as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
        discard  <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_ok && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .din   (buf_din),
    .head  (buf_head),
    .count (buf_count)
  );

  // PCs of issued requests, oldest first; responses return in order, so the
  // head always names the word arriving on imem_rdata. Never flushed: stale
  // entries are retired one by one as their discarded responses arrive.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (rsp_ok),
    .flush (1'b0),
    .din   (pcq_din),
    .head  (pcq_head),
    .count (pcq_count)
  );

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (inflight != '0));

  a_pcq_tracks_inflight: assert property (@(posedge clk) disable iff (rst)
    (pcq_count == inflight) && (pcq_head.instr == '0));

  a_credit_budget: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, inflight} + {1'b0, buf_count}) <= (CW + 1)'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an in-order memory model and a
// stream-level reference: delivered PCs must follow the last redirect target
// in steps of 4, data must match memory, and request/valid behaviour follows
// an epoch-based count of live responses.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] pop_log[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          n_pops = 0;
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] exp_pc = RESET_PC;
  int          gnt_pct = 100;
  int          rdy_pct = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          redir_req = 0;
  logic [31:0] redir_target = '0;
  bit          hold_pending = 0;
  logic [31:0] hold_addr = '0;
  bit          stall_pending = 0;
  logic [31:0] stall_instr = '0;
  logic [31:0] stall_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0226_8193 ^ (a * 32'h9E37_79B1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    pend.delete();
    buffered = 0;
    epoch++;
    exp_req = RESET_PC;
    exp_pc = RESET_PC;
    hold_pending = 0;
    stall_pending = 0;
    redir_req = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check settled outputs,
  // then advance the reference to the state after the coming rising edge.
  task automatic step();
    bit    rv;
    bit    stale;
    bit    pop_now;
    int    infl_before;
    pend_t r;
    @(negedge clk);
    rv = 0;
    stale = 0;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      rv = 1;
      stale = (r.ep != epoch);
      imem_rvalid = 1'b1;
      imem_rdata = mem_word(r.addr);
    end
    infl_before = pend.size() + int'(rv);
    imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    instr_ready = ($urandom_range(0, 99) < rdy_pct);
    redirect_valid = redir_req;
    redirect_pc = redir_target;
    redir_req = 0;
    #1;
    check("valid", 32'(instr_valid), 32'(buffered != 0));
    check("req", 32'(imem_req), 32'(!redirect_valid && (infl_before + buffered < DEPTH)));
    if (imem_req) check("addr", imem_addr, exp_req);
    if (hold_pending && !redirect_valid) begin
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, hold_addr);
    end
    if (stall_pending) begin
      check("instr_hold", instr, stall_instr);
      check("pc_hold", instr_pc, stall_pc);
    end
    pop_now = instr_valid && instr_ready && !redirect_valid;
    if (pop_now) begin
      check("out_pc", instr_pc, exp_pc);
      check("out_instr", instr, mem_word(exp_pc));
      pop_log.push_back(instr_pc);
      exp_pc += 32'd4;
      n_pops++;
    end
    hold_pending = imem_req && !imem_gnt && !redirect_valid;
    hold_addr = imem_addr;
    stall_pending = instr_valid && !instr_ready && !redirect_valid;
    stall_instr = instr;
    stall_pc = instr_pc;
    if (imem_req && imem_gnt) begin
      pend.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_min, lat_max), ep: epoch});
      exp_req += 32'd4;
    end
    if (rv && !stale && !redirect_valid) buffered++;
    if (pop_now) buffered--;
    if (redirect_valid) begin
      epoch++;
      buffered = 0;
      exp_req = redirect_pc & ~32'h3;
      exp_pc = redirect_pc & ~32'h3;
    end
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    int          k;
    logic [31:0] a0;

    // T1: reset, first request and first delivered word.
    apply_reset();
    gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
    step();
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    step();
    step();
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_instr", instr, 32'h0226_8193);
    check("t1_pc", instr_pc, 32'h0);

    // T2: continuous stream with a one-cycle memory.
    rdy_pct = 100;
    p0 = n_pops;
    repeat (18) step();
    check("t2_words", 32'(n_pops - p0 >= 10), 32'd1);
    check("t2_progress", 32'(exp_pc >= 32'h20), 32'd1);

    // T3: core backpressure, then release.
    rdy_pct = 0;
    repeat (10) step();
    check("t3_req", 32'(imem_req), 32'd0);
    check("t3_valid", 32'(instr_valid), 32'd1);
    rdy_pct = 100;
    p0 = n_pops;
    repeat (10) step();
    check("t3_resume", 32'(n_pops > p0), 32'd1);

    // T4: redirect with two requests in flight.
    lat_min = 4; lat_max = 4;
    redir_req = 1; redir_target = 32'h40;
    step();
    k = 0;
    while (!(pend.size() == 2 && pend[0].ep == epoch) && k < 20) begin
      step();
      k++;
    end
    check("t4_two_inflight", 32'(pend.size()), 32'd2);
    redir_req = 1; redir_target = 32'h102;
    step();
    step();
    check("t4_addr", imem_addr, 32'h100);
    pop_log.delete();
    k = 0;
    while (pop_log.size() == 0 && k < 30) begin
      step();
      k++;
    end
    check("t4_first_pc", (pop_log.size() != 0) ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

    // T5: grant stall holds the address; redirect across the top of memory wraps.
    lat_min = 1; lat_max = 1;
    gnt_pct = 0;
    k = 0;
    while ((pend.size() != 0 || buffered != 0) && k < 40) begin
      step();
      k++;
    end
    check("t5_drained", 32'(pend.size() + buffered), 32'd0);
    step();
    a0 = imem_addr;
    check("t5_req", 32'(imem_req), 32'd1);
    repeat (5) begin
      step();
      check("t5_addr_stable", imem_addr, a0);
    end
    gnt_pct = 100;
    redir_req = 1; redir_target = 32'hFFFF_FFFC;
    pop_log.delete();
    k = 0;
    while (pop_log.size() < 2 && k < 30) begin
      step();
      k++;
    end
    check("t5_pc0", (pop_log.size() >= 1) ? pop_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("t5_pc1", (pop_log.size() >= 2) ? pop_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // T6: reset while the buffer is full.
    rdy_pct = 0;
    repeat (8) step();
    check("t6_valid_before", 32'(instr_valid), 32'd1);
    apply_reset();
    step();
    check("t6_req", 32'(imem_req), 32'd1);
    check("t6_addr", imem_addr, RESET_PC);

    // Randomized traffic: grant/ready rates, latency, redirects and resets.
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        rdy_pct = $urandom_range(20, 100);
        lat_max = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 99) < 3) begin
        redir_req = 1;
        redir_target = $urandom;
      end
      if ($urandom_range(0, 499) == 0) apply_reset();
      else step();
    end
    check("rand_progress", 32'(n_pops > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
